// File: rtl/i2c_slave_line_cond.sv
// SCL/SDA input conditioning for the I2C slave: 2-FF sync, glitch filter,
// START/STOP detection, bus-busy tracking and SMBus-style SCL-low timeout.
module i2c_slave_line_cond #(
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned TO_W     = 20
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            ena,
  input  logic            scl_pad_i,
  input  logic            sda_pad_i,
  input  logic            scl_oen_i,
  input  logic            to_en,
  input  logic [TO_W-1:0] timeout_cycles,
  input  logic            to_clr,
  output logic            scl_o,
  output logic            sda_o,
  output logic            start_det,
  output logic            stop_det,
  output logic            bus_busy,
  output logic            slv_autoreset,
  output logic            timeout_flag
);

  localparam logic [3:0] FILT_LEN_C = 4'(FILT_LEN);

  // Bit 0 carries SCL, bit 1 carries SDA throughout.
  logic            clr_s;
  logic [1:0]      pad_s;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      filt_q, filt_d;
  logic [1:0]      prev_q;
  logic [3:0]      fcnt_q [2];
  logic [3:0]      fcnt_d [2];
  logic            scl_f_s, sda_f_s;
  logic            start_q, start_d;
  logic            stop_q, stop_d;
  logic            busy_q, busy_d;
  logic            autoreset_q;
  logic            flag_q, flag_d;
  logic            to_sat_q, to_sat_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            count_en_s;
  logic            expire_s;

  assign clr_s   = rst_ | ~ena;
  assign pad_s   = {sda_pad_i, scl_pad_i};
  assign scl_f_s = filt_q[0];
  assign sda_f_s = filt_q[1];

  // Glitch filter: with FILT_LEN=0 the filtered flop acts as the second sync stage.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      fcnt_d[i] = 4'd0;
      if (FILT_LEN == 32'd0) begin
        filt_d[i] = sync1_q[i];
      end else if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] + 4'd1 == FILT_LEN_C) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 4'd1;
        end
      end else begin
        fcnt_d[i] = 4'd0;
      end
    end
  end

  // Self-stretch (scl_oen_i=0) pauses the count; to_sat_q blocks re-arming until SCL goes high.
  assign count_en_s = to_en & (timeout_cycles != '0) & busy_q & ~scl_f_s
                    & scl_oen_i & ~to_sat_q;
  assign expire_s   = count_en_s & (to_cnt_q >= (timeout_cycles - TO_W'(1)));

  // Condition detect, bus-busy, timeout counter and sticky flag next-state.
  always_comb begin
    start_d  = scl_f_s & prev_q[0] & prev_q[1] & ~sda_f_s;
    stop_d   = scl_f_s & prev_q[0] & ~prev_q[1] & sda_f_s;
    busy_d   = busy_q;
    to_cnt_d = to_cnt_q;
    to_sat_d = to_sat_q;
    flag_d   = flag_q;
    if (expire_s) begin
      busy_d = 1'b0;
    end else if (start_q) begin
      busy_d = 1'b1;
    end else if (stop_q) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (scl_f_s || !busy_q || expire_s) begin
      to_cnt_d = '0;
    end else if (count_en_s) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end
    if (scl_f_s) begin
      to_sat_d = 1'b0;
    end else if (expire_s) begin
      to_sat_d = 1'b1;
    end else begin
      to_sat_d = to_sat_q;
    end
    if (expire_s) begin
      flag_d = 1'b1;
    end else if (to_clr) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  // State registers; reset or disable forces the idle-bus state.
  always_ff @(posedge clk) begin
    if (clr_s) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      prev_q      <= 2'b11;
      fcnt_q[0]   <= 4'd0;
      fcnt_q[1]   <= 4'd0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      autoreset_q <= 1'b0;
      flag_q      <= 1'b0;
      to_sat_q    <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      sync1_q     <= pad_s;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      prev_q      <= filt_q;
      fcnt_q[0]   <= fcnt_d[0];
      fcnt_q[1]   <= fcnt_d[1];
      start_q     <= start_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      autoreset_q <= expire_s;
      flag_q      <= flag_d;
      to_sat_q    <= to_sat_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign scl_o         = filt_q[0];
  assign sda_o         = filt_q[1];
  assign start_det     = start_q;
  assign stop_det      = stop_q;
  assign bus_busy      = busy_q;
  assign slv_autoreset = autoreset_q;
  assign timeout_flag  = flag_q;

endmodule

// File: tb/tb_i2c_slave_line_cond.sv
// Bench for i2c_slave_line_cond: directed scenarios plus random pad activity,
// every cycle compared against a window/run-length reference model.
module tb_i2c_slave_line_cond;

  localparam int FL = 3;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          rst_, ena, scl_pad, sda_pad, scl_oen, to_en, to_clr;
  logic [TW-1:0] tc;
  logic          scl_o, sda_o, start_det, stop_det, bus_busy, slv_ar, to_flag;

  always #5 clk = ~clk;

  i2c_slave_line_cond #(.FILT_LEN(FL), .TO_W(TW)) dut (
    .clk(clk), .rst_(rst_), .ena(ena),
    .scl_pad_i(scl_pad), .sda_pad_i(sda_pad), .scl_oen_i(scl_oen),
    .to_en(to_en), .timeout_cycles(tc), .to_clr(to_clr),
    .scl_o(scl_o), .sda_o(sda_o), .start_det(start_det), .stop_det(stop_det),
    .bus_busy(bus_busy), .slv_autoreset(slv_ar), .timeout_flag(to_flag)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pad history window, filtered-line history, low-time accounting.
  logic [17:0] hs, hd;
  bit m_scl, m_sda, m_scl_p, m_sda_p, m_start, m_stop, m_busy, m_ar, m_flag, m_fired;
  int m_low;

  function automatic bit filt_next(input logic [17:0] h, input bit f);
    if (FL == 0) return h[1];
    for (int i = 2; i < FL + 2; i++)
      if (h[i] == f) return f;
    return ~f;
  endfunction

  task automatic model_edge();
    bit cnting, expire, n_busy, n_fired, n_flag, n_start, n_stop;
    int n_low;
    if (rst_ || !ena) begin
      hs = '1; hd = '1;
      m_scl = 1; m_sda = 1; m_scl_p = 1; m_sda_p = 1;
      m_start = 0; m_stop = 0; m_busy = 0; m_ar = 0; m_flag = 0; m_fired = 0; m_low = 0;
    end else begin
      cnting  = to_en && (tc != 0) && m_busy && !m_scl && scl_oen && !m_fired;
      expire  = cnting && (m_low + 1 >= int'(tc));
      n_busy  = expire ? 1'b0 : (m_start ? 1'b1 : (m_stop ? 1'b0 : m_busy));
      n_low   = (m_scl || !m_busy || expire) ? 0 : (cnting ? m_low + 1 : m_low);
      n_fired = m_scl ? 1'b0 : (expire ? 1'b1 : m_fired);
      n_flag  = expire ? 1'b1 : (to_clr ? 1'b0 : m_flag);
      n_start = m_scl && m_scl_p && m_sda_p && !m_sda;
      n_stop  = m_scl && m_scl_p && !m_sda_p && m_sda;
      hs = {hs[16:0], scl_pad};
      hd = {hd[16:0], sda_pad};
      m_scl_p = m_scl;
      m_sda_p = m_sda;
      m_scl   = filt_next(hs, m_scl);
      m_sda   = filt_next(hd, m_sda);
      m_start = n_start; m_stop = n_stop; m_busy = n_busy; m_ar = expire;
      m_flag  = n_flag;  m_fired = n_fired; m_low = n_low;
    end
  endtask

  int cyc = 0;
  int n_start = 0, n_stop = 0, n_ar = 0, n_busy_cyc = 0, n_sda_fall = 0;
  int start_cyc = 0, stop_cyc = 0, ar_cyc = 0, scl_fall_cyc = 0, sda_fall_cyc = 0;
  logic prev_scl_o = 1'b1, prev_sda_o = 1'b1;

  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    check_eq("scl_o", scl_o, m_scl);
    check_eq("sda_o", sda_o, m_sda);
    check_eq("start_det", start_det, m_start);
    check_eq("stop_det", stop_det, m_stop);
    check_eq("bus_busy", bus_busy, m_busy);
    check_eq("slv_autoreset", slv_ar, m_ar);
    check_eq("timeout_flag", to_flag, m_flag);
    if (start_det === 1'b1) begin n_start++; start_cyc = cyc; end
    if (stop_det === 1'b1) begin n_stop++; stop_cyc = cyc; end
    if (slv_ar === 1'b1) begin n_ar++; ar_cyc = cyc; end
    if (bus_busy === 1'b1) n_busy_cyc++;
    if (prev_scl_o === 1'b1 && scl_o === 1'b0) scl_fall_cyc = cyc;
    if (prev_sda_o === 1'b1 && sda_o === 1'b0) begin n_sda_fall++; sda_fall_cyc = cyc; end
    prev_scl_o = scl_o;
    prev_sda_o = sda_o;
  endtask

  task automatic set_lines(input bit c, input bit d, input int n);
    scl_pad = c;
    sda_pad = d;
    repeat (n) tick();
  endtask

  // Drop SCL and wait (bounded) for the filtered fall; returns its cycle.
  task automatic scl_low_wait(output int f);
    int c0;
    c0 = cyc;
    scl_pad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (scl_fall_cyc > c0) break;
      tick();
    end
    check_eq("scl_fall_seen", scl_fall_cyc > c0, 1);
    f = scl_fall_cyc;
  endtask

  task automatic go_idle();
    set_lines(1'b1, 1'b0, 8);
    set_lines(1'b1, 1'b1, 8);
    to_clr = 1'b1;
    tick();
    to_clr = 1'b0;
  endtask

  initial begin
    int c0, s0, p0, b0, a0, f0, f;
    bit d, dprev;
    int scl_hold, sda_hold;

    rst_ = 1; ena = 1; scl_pad = 1; sda_pad = 1; scl_oen = 1;
    to_en = 0; tc = '0; to_clr = 0;
    repeat (3) tick();
    check_eq("rst_scl_o", scl_o, 1);
    check_eq("rst_sda_o", sda_o, 1);
    check_eq("rst_busy", bus_busy, 0);
    check_eq("rst_flag", to_flag, 0);
    rst_ = 0;
    repeat (4) tick();

    // 2-cycle SDA glitch with SCL high must be swallowed
    s0 = n_start; f0 = n_sda_fall;
    set_lines(1'b1, 1'b0, 2);
    set_lines(1'b1, 1'b1, 12);
    check_eq("glitch_start", n_start - s0, 0);
    check_eq("glitch_sda_fall", n_sda_fall - f0, 0);

    // 3-cycle pulse passes: sda_o at +5, start_det at +6
    c0 = cyc; s0 = n_start;
    set_lines(1'b1, 1'b0, 3);
    set_lines(1'b1, 1'b1, 12);
    check_eq("pulse_sda_lat", sda_fall_cyc - c0, 2 + FL);
    check_eq("pulse_start_lat", start_cyc - c0, 3 + FL);
    check_eq("pulse_start_cnt", n_start - s0, 1);

    // Full frame: START, 9 clocks with SDA changing only while SCL low, STOP
    s0 = n_start; p0 = n_stop; b0 = n_busy_cyc;
    set_lines(1'b1, 1'b0, 8);
    dprev = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d = 1'($urandom_range(0, 1));
      set_lines(1'b0, dprev, 8);
      set_lines(1'b0, d, 8);
      set_lines(1'b1, d, 8);
      dprev = d;
    end
    set_lines(1'b0, dprev, 8);
    set_lines(1'b0, 1'b0, 8);
    set_lines(1'b1, 1'b0, 8);
    set_lines(1'b1, 1'b1, 8);
    check_eq("frame_starts", n_start - s0, 1);
    check_eq("frame_stops", n_stop - p0, 1);
    check_eq("frame_busy_len", n_busy_cyc - b0, stop_cyc - start_cyc);
    check_eq("frame_idle_busy", bus_busy, 0);

    // Timeout 100 with to_clr colliding with expiry, then held low 500 more
    to_en = 1; tc = TW'(100);
    a0 = n_ar;
    set_lines(1'b1, 1'b0, 10);
    scl_low_wait(f);
    repeat (99) tick();
    check_eq("to_no_early", n_ar - a0, 0);
    to_clr = 1'b1;
    tick();
    check_eq("to_latency", ar_cyc - f, 100);
    check_eq("to_flag_set_wins", to_flag, 1);
    check_eq("to_busy_clr", bus_busy, 0);
    tick();
    check_eq("to_flag_cleared", to_flag, 0);
    to_clr = 1'b0;
    repeat (500) tick();
    check_eq("to_single_pulse", n_ar - a0, 1);
    go_idle();

    // Self-stretch for 50 cycles delays expiry by 50
    a0 = n_ar;
    set_lines(1'b1, 1'b0, 10);
    scl_low_wait(f);
    repeat (20) tick();
    scl_oen = 1'b0;
    repeat (50) tick();
    scl_oen = 1'b1;
    repeat (200) tick();
    check_eq("stretch_latency", ar_cyc - f, 150);
    check_eq("stretch_pulses", n_ar - a0, 1);
    go_idle();

    // Reset mid low-period, then a fresh START needs a full 100 cycles
    a0 = n_ar;
    set_lines(1'b1, 1'b0, 10);
    scl_low_wait(f);
    repeat (60) tick();
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    check_eq("mid_rst_scl_o", scl_o, 1);
    check_eq("mid_rst_sda_o", sda_o, 1);
    check_eq("mid_rst_start", start_det, 0);
    check_eq("mid_rst_stop", stop_det, 0);
    check_eq("mid_rst_busy", bus_busy, 0);
    check_eq("mid_rst_ar", slv_ar, 0);
    check_eq("mid_rst_flag", to_flag, 0);
    repeat (300) tick();
    check_eq("post_rst_no_ar", n_ar - a0, 0);
    set_lines(1'b1, 1'b0, 8);
    set_lines(1'b1, 1'b1, 8);
    set_lines(1'b1, 1'b0, 10);
    scl_low_wait(f);
    repeat (99) tick();
    check_eq("restart_no_early", n_ar - a0, 0);
    tick();
    check_eq("restart_latency", ar_cyc - f, 100);
    go_idle();

    // Random pad activity, stretch, timeout settings, clears, resets, disables
    scl_hold = 1; sda_hold = 1;
    tc = TW'(12);
    for (int n = 0; n < 4000; n++) begin
      scl_hold--;
      sda_hold--;
      if (scl_hold <= 0) begin scl_pad = ~scl_pad; scl_hold = $urandom_range(1, 14); end
      if (sda_hold <= 0) begin sda_pad = ~sda_pad; sda_hold = $urandom_range(1, 14); end
      if ($urandom_range(0, 19) == 0) scl_oen = ~scl_oen;
      if ($urandom_range(0, 99) == 0) to_en = ~to_en;
      if ($urandom_range(0, 149) == 0) tc = TW'($urandom_range(0, 25));
      to_clr = ($urandom_range(0, 15) == 0);
      rst_   = ($urandom_range(0, 599) == 0);
      ena    = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_ = 0; ena = 1; to_clr = 0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_slave_line_cond.md
Name: i2c_slave_line_cond

Overview:
Conditions the raw SCL/SDA pad inputs before they reach the I2C slave byte/bit controller.
- Synchronises each line, then applies a digital glitch filter.
- Detects START/STOP on the filtered lines and tracks bus-busy.
- Runs an SMBus-style SCL-low timeout. On expiry it drives the controller's slv_autoreset so that a hung transfer is aborted.
- Sits directly upstream of i2c_slave_byte_ctrl: scl_o/sda_o feed its scl_i/sda_i, slv_autoreset feeds its slv_autoreset, and its scl_oen is fed back here.

Parameters:
FILT_LEN, 3, consecutive cycles a synced line must differ from the filtered value before the filtered value flips; 0 = filter bypass; legal 0..15
TO_W, 20, width of the timeout counter and of timeout_cycles

Ports:
clk  input  1  system clock
rst_  input  1  reset, synchronous, active-high (1 = reset)
ena  input  1  core enable; low holds the block in its reset state
scl_pad_i  input  1  raw SCL from pad
sda_pad_i  input  1  raw SDA from pad
scl_oen_i  input  1  own SCL output enable from the byte controller (0 = this slave is stretching SCL)
to_en  input  1  timeout enable
timeout_cycles  input  TO_W  SCL-low timeout in clk cycles; 0 disables the timeout
to_clr  input  1  single-cycle clear of timeout_flag
scl_o  output  1  filtered SCL
sda_o  output  1  filtered SDA
start_det  output  1  1-cycle pulse on START / repeated START
stop_det  output  1  1-cycle pulse on STOP
bus_busy  output  1  bus owned between START and STOP/timeout
slv_autoreset  output  1  1-cycle pulse on timeout expiry
timeout_flag  output  1  sticky timeout status

Behaviour:
- Reset (rst_=1, or ena=0 at a clock edge):
  - Sync flops and filtered values go to 1; filter counters and the timeout counter go to 0.
  - scl_o=1, sda_o=1, start_det=0, stop_det=0, bus_busy=0, slv_autoreset=0, timeout_flag=0.
- Synchroniser: 2-FF per line.
- Filter, per line, independent:
  - Counter increments while the synced value differs from the filtered value, and clears when they match.
  - When the counter reaches FILT_LEN, the filtered value takes the synced value and the counter clears.
  - A pulse shorter than FILT_LEN cycles (after sync) never appears on the output.
  - Pad-to-output latency is 2+FILT_LEN cycles; with FILT_LEN=0 it is 2 cycles (pure sync).
- Condition detect on filtered lines, using a registered previous value of each line:
  - START: sda falls while scl is high in both the previous and current cycle.
  - STOP: sda rises while scl is high in both the previous and current cycle.
  - start_det/stop_det are asserted in the cycle after the filtered edge.
  - If scl and sda change in the same cycle, no condition is detected.
- bus_busy:
  - Set on start_det (a repeated START keeps it set).
  - Cleared on stop_det or on a timeout.
  - If start_det and the timeout pulse coincide, the clear wins.
- Timeout counter:
  - Counts only when to_en=1, timeout_cycles!=0, bus_busy=1, scl_o=0 and scl_oen_i=1. Self-stretch is excluded.
  - Clears to 0 whenever scl_o=1, and whenever bus_busy=0 outside the expiry cycle.
  - If scl_oen_i=0 it holds its value (pauses) rather than clearing.
  - Expiry: in the cycle the counter equals timeout_cycles-1 while counting, the next edge produces:
    - slv_autoreset=1 for exactly one cycle;
    - timeout_flag=1;
    - bus_busy=0;
    - the counter set to a saturated state.
  - No further pulse until scl_o has returned high.
- timeout_flag: cleared by to_clr; if set and clear occur in the same cycle, set wins.
- Changing timeout_cycles mid-count takes effect on the next comparison; if the counter is already ≥ the new value, expiry occurs on the next counting cycle.

Test Plan:
- FILT_LEN=3, SDA low pulse of 2 cycles with SCL high → sda_o stays 1, no start_det. Pulse of 3 cycles → sda_o falls exactly 5 cycles after the pad edge, and start_det pulses one cycle later.
- START (SDA↓ with SCL=1), 9 SCL clocks, then STOP → one start_det; bus_busy=1 from start_det+1 until stop_det+1; one stop_det; no spurious conditions during the SDA changes while SCL is low.
- to_en=1, timeout_cycles=100, START then SCL held low → slv_autoreset pulses exactly once, 100 counting cycles after scl_o falls; timeout_flag=1, bus_busy=0. Held low a further 500 cycles → no second pulse.
- Same as above but scl_oen_i=0 for 50 of those cycles → expiry is delayed by exactly 50 cycles.
- Assert rst_=1 for one cycle after 60 low cycles → all outputs return to their reset values (scl_o/sda_o=1, others 0); no slv_autoreset follows until a new START and a full 100-cycle low period.
- Assert to_clr in the same cycle as expiry → timeout_flag=1. to_clr on the following cycle → timeout_flag=0.
